spi_write_arbiter: RTL and testbench
====================================

Name: spi_write_arbiter

Overview:
- Shares one send-only SPI write master (CPOL=0/CPHA=0, start/busy/done handshake) between NUM_REQ independent requesters.
- Round-robin arbitration; latches the winner's address/data, launches exactly one SPI write, waits for completion, returns a per-requester ack or err pulse.
- Enforces a minimum idle gap between writes and a watchdog against a hung master.
- Sits between the configuration logic blocks and the SPI master instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_BITS, 8, SPI address width; must match the master
- DATA_BITS, 16, SPI data width; must match the master
- RATIO_W, 8, width of the SPI clock-ratio field passed to the master
- GAP_CYCLES, 4, idle clk cycles after each transaction before the next arbitration (0 allowed)
- WDOG_CYCLES, 4096, max clk cycles in any wait state before abort

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-requester write request (level)
- req_addr  in  NUM_REQ*ADDR_BITS  packed addresses; requester i at [i*ADDR_BITS +: ADDR_BITS]
- req_data  in  NUM_REQ*DATA_BITS  packed data, same packing
- cfg_ratio  in  RATIO_W  clk:SCLK ratio for all writes (>=2)
- ack  out  NUM_REQ  one-cycle pulse: requester's write completed
- err  out  NUM_REQ  one-cycle pulse: requester's write aborted by watchdog
- grant_id  out  $clog2(NUM_REQ)  index of the current/last granted requester
- arb_busy  out  1  high from grant until GAP expires
- spi_start  out  1  one-cycle start pulse to the master
- spi_address  out  ADDR_BITS  latched address to the master
- spi_data  out  DATA_BITS  latched data to the master
- spi_ratio  out  RATIO_W  latched ratio to the master
- spi_busy  in  1  master busy
- spi_done  in  1  master one-cycle completion pulse

Behaviour:
- Reset (async, immediate): state IDLE; ack, err, spi_start, arb_busy = 0; grant_id = NUM_REQ-1 (so requester 0 wins first); spi_address/spi_data/spi_ratio = 0; gap and watchdog counters = 0. Reset mid-transfer abandons it; no ack/err issued.
- All outputs registered.
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE: if |req, winner = first set bit scanning grant_id+1, grant_id+2, ... modulo NUM_REQ. Same edge: grant_id <= winner; operands and cfg_ratio latched; arb_busy <= 1; spi_start <= 1; -> LAUNCH.
- LAUNCH (1 cycle): spi_start <= 0; watchdog cleared; -> WAIT_BUSY.
- WAIT_BUSY: spi_busy=1 -> WAIT_DONE, watchdog cleared. Also accept spi_done=1 here as completion (ack path).
- WAIT_DONE: spi_done=1 -> ack[grant_id] pulses 1 cycle; -> GAP.
- Watchdog: in WAIT_BUSY/WAIT_DONE, counter reaching WDOG_CYCLES-1 without exit -> err[grant_id] pulses 1 cycle; -> GAP. ack and err never both set.
- GAP: counts GAP_CYCLES clk, then arb_busy <= 0, -> IDLE. GAP_CYCLES=0: GAP lasts one cycle.
- Latency: req rising in IDLE -> spi_start high on next edge (1 cycle).
- Requesters hold req/operands until ack or err; req dropped after grant does not cancel the write; ack still pulses.
- req changes outside IDLE are ignored until next arbitration.
- Operands are latched at grant; later changes on req_addr/req_data do not affect the in-flight write.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 transactions.
- Round-robin pointer advances only on grant, including aborted grants.

Test Plan:
- Single req[2]=1, addr 0x5A, data 0xBEEF, ratio 8, GAP 4 -> spi_start 1 cycle after req; spi_address=0x5A, spi_data=0xBEEF; ack[2] one pulse the cycle after spi_done; arb_busy low 4 cycles later.
- req=4'b1111 held continuously -> grant order 0,1,2,3,0; each ack exactly once per transaction; consecutive spi_start pulses separated by at least GAP_CYCLES idle cycles.
- req[1] and req[3] together with grant_id=1 -> requester 3 served first, then 1.
- Stub master never asserts busy/done, WDOG 16 -> err[grant] pulses after 16 cycles in WAIT_BUSY; no ack; next requester then served.
- Assert reset during WAIT_DONE -> all outputs 0 and grant_id=NUM_REQ-1 immediately (async); no ack/err; after release with req[0]=1, requester 0 is granted.
- Change req_data of the granted requester during WAIT_DONE -> spi_data stays at the latched value.

Source files
------------

// File: rtl/spi_write_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : spi_write_arbiter_if
//  Brief    : Command/handshake bundle between the write arbiter and the
//             send-only SPI write master.
//  Revision : 1.0 - initial release
// ============================================================================
interface spi_write_arbiter_if #(
   parameter int ADDR_BITS = 8,
   parameter int DATA_BITS = 16,
   parameter int RATIO_W   = 8
);
   logic                 spi_start;
   logic [ADDR_BITS-1:0] spi_address;
   logic [DATA_BITS-1:0] spi_data;
   logic [RATIO_W-1:0]   spi_ratio;
   logic                 spi_busy;
   logic                 spi_done;

   // Arbiter side issues commands; the SPI master answers with busy/done.
   modport master (
      output spi_start, spi_address, spi_data, spi_ratio,
      input  spi_busy, spi_done
   );

   modport slave (
      input  spi_start, spi_address, spi_data, spi_ratio,
      output spi_busy, spi_done
   );
endinterface
`default_nettype wire

// File: rtl/spi_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : spi_write_arbiter
//  Brief    : Round-robin arbiter sharing one SPI write master between
//             NUM_REQ requesters, with post-write idle gap and watchdog.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_write_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int ADDR_BITS   = 8,
   parameter int DATA_BITS   = 16,
   parameter int RATIO_W     = 8,
   parameter int GAP_CYCLES  = 4,
   parameter int WDOG_CYCLES = 4096
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ*ADDR_BITS-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
   input  logic [RATIO_W-1:0]             cfg_ratio,
   output logic [NUM_REQ-1:0]             ack,
   output logic [NUM_REQ-1:0]             err,
   output logic [$clog2(NUM_REQ)-1:0]     grant_id,
   output logic                           arb_busy,
   spi_write_arbiter_if.master            spi
);
   localparam int c_GID_W  = $clog2(NUM_REQ);
   localparam int c_WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
   localparam int c_GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [c_WDOG_W-1:0] c_WDOG_LAST = c_WDOG_W'(WDOG_CYCLES - 1);
   localparam logic [c_GAP_W-1:0]  c_GAP_LAST  = c_GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   localparam logic [2:0] c_IDLE      = 3'd0;
   localparam logic [2:0] c_LAUNCH    = 3'd1;
   localparam logic [2:0] c_WAIT_BUSY = 3'd2;
   localparam logic [2:0] c_WAIT_DONE = 3'd3;
   localparam logic [2:0] c_GAP       = 3'd4;

   logic [2:0]           r_state, w_state_nxt;
   logic [c_WDOG_W-1:0]  r_wdog, w_wdog_nxt;
   logic [c_GAP_W-1:0]   r_gap, w_gap_nxt;
   logic [NUM_REQ-1:0]   w_ack_nxt, w_err_nxt;
   logic [c_GID_W-1:0]   w_gid_nxt, w_winner, w_cand;
   logic                 w_found, w_busy_nxt, w_start_nxt;
   logic [ADDR_BITS-1:0] w_addr_nxt;
   logic [DATA_BITS-1:0] w_data_nxt;
   logic [RATIO_W-1:0]   w_ratio_nxt;
   logic                 w_wdog_exp, w_gap_exp;

   logic [ADDR_BITS-1:0] w_addr_arr [NUM_REQ];
   logic [DATA_BITS-1:0] w_data_arr [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_addr_arr[gi] = req_addr[gi*ADDR_BITS +: ADDR_BITS];
      assign w_data_arr[gi] = req_data[gi*DATA_BITS +: DATA_BITS];
   end

   assign w_wdog_exp = (r_wdog == c_WDOG_LAST);
   assign w_gap_exp  = (r_gap == c_GAP_LAST);

   // Scan starts one past the last grant so every requester gets its turn.
   always_comb begin
      w_winner = grant_id;
      w_found  = 1'b0;
      w_cand   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_cand = c_GID_W'((int'(grant_id) + k) % NUM_REQ);
         if (!w_found && req[w_cand]) begin
            w_winner = w_cand;
            w_found  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state         <= c_IDLE;
         r_wdog          <= '0;
         r_gap           <= '0;
         ack             <= '0;
         err             <= '0;
         grant_id        <= c_GID_W'(NUM_REQ - 1);
         arb_busy        <= 1'b0;
         spi.spi_start   <= 1'b0;
         spi.spi_address <= '0;
         spi.spi_data    <= '0;
         spi.spi_ratio   <= '0;
      end else begin
         r_state         <= w_state_nxt;
         r_wdog          <= w_wdog_nxt;
         r_gap           <= w_gap_nxt;
         ack             <= w_ack_nxt;
         err             <= w_err_nxt;
         grant_id        <= w_gid_nxt;
         arb_busy        <= w_busy_nxt;
         spi.spi_start   <= w_start_nxt;
         spi.spi_address <= w_addr_nxt;
         spi.spi_data    <= w_data_nxt;
         spi.spi_ratio   <= w_ratio_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE:      if (|req) w_state_nxt = c_LAUNCH;
         c_LAUNCH:    w_state_nxt = c_WAIT_BUSY;
         c_WAIT_BUSY: begin
            if (spi.spi_done)      w_state_nxt = c_GAP;
            else if (spi.spi_busy) w_state_nxt = c_WAIT_DONE;
            else if (w_wdog_exp)   w_state_nxt = c_GAP;
         end
         c_WAIT_DONE: if (spi.spi_done || w_wdog_exp) w_state_nxt = c_GAP;
         c_GAP:       if (w_gap_exp) w_state_nxt = c_IDLE;
         default:     w_state_nxt = c_IDLE;
      endcase
   end

   always_comb begin
      w_ack_nxt   = '0;
      w_err_nxt   = '0;
      w_start_nxt = 1'b0;
      w_busy_nxt  = arb_busy;
      w_gid_nxt   = grant_id;
      w_addr_nxt  = spi.spi_address;
      w_data_nxt  = spi.spi_data;
      w_ratio_nxt = spi.spi_ratio;
      w_wdog_nxt  = r_wdog;
      w_gap_nxt   = r_gap;
      case (r_state)
         c_IDLE: begin
            if (|req) begin
               w_gid_nxt   = w_winner;
               w_addr_nxt  = w_addr_arr[w_winner];
               w_data_nxt  = w_data_arr[w_winner];
               w_ratio_nxt = cfg_ratio;
               w_busy_nxt  = 1'b1;
               w_start_nxt = 1'b1;
            end
         end
         c_LAUNCH: w_wdog_nxt = '0;
         c_WAIT_BUSY, c_WAIT_DONE: begin
            // A done seen before busy still counts as a completed write.
            if (spi.spi_done) begin
               w_ack_nxt[grant_id] = 1'b1;
               w_gap_nxt           = '0;
            end else if (spi.spi_busy && (r_state == c_WAIT_BUSY)) begin
               w_wdog_nxt = '0;
            end else if (w_wdog_exp) begin
               w_err_nxt[grant_id] = 1'b1;
               w_gap_nxt           = '0;
            end else begin
               w_wdog_nxt = r_wdog + c_WDOG_W'(1);
            end
         end
         c_GAP: begin
            if (w_gap_exp) w_busy_nxt = 1'b0;
            else           w_gap_nxt  = r_gap + c_GAP_W'(1);
         end
         default: ;
      endcase
   end
endmodule
`default_nettype wire

// File: tb/tb_spi_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_write_arbiter
//  Brief    : Randomized scoreboard bench for spi_write_arbiter with a stub
//             SPI master and a transaction-level round-robin model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_write_arbiter;
   localparam int NUM_REQ     = 4;
   localparam int ADDR_BITS   = 8;
   localparam int DATA_BITS   = 16;
   localparam int RATIO_W     = 8;
   localparam int GAP_CYCLES  = 4;
   localparam int WDOG_CYCLES = 16;

   logic                         clk = 1'b0;
   logic                         reset = 1'b1;
   logic [NUM_REQ-1:0]           req = '0;
   logic [NUM_REQ*ADDR_BITS-1:0] req_addr = '0;
   logic [NUM_REQ*DATA_BITS-1:0] req_data = '0;
   logic [RATIO_W-1:0]           cfg_ratio = 8'd2;
   logic [NUM_REQ-1:0]           ack, err;
   logic [1:0]                   grant_id;
   logic                         arb_busy;

   spi_write_arbiter_if #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS), .RATIO_W(RATIO_W)) spi_if ();

   spi_write_arbiter #(
      .NUM_REQ(NUM_REQ), .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS),
      .RATIO_W(RATIO_W), .GAP_CYCLES(GAP_CYCLES), .WDOG_CYCLES(WDOG_CYCLES)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_data(req_data),
      .cfg_ratio(cfg_ratio), .ack(ack), .err(err), .grant_id(grant_id),
      .arb_busy(arb_busy), .spi(spi_if)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // mode: 0 busy-then-done, 1 done only, 2 silent master, 3 busy stuck
   typedef struct {
      int                   id;
      logic [ADDR_BITS-1:0] addr;
      logic [DATA_BITS-1:0] data;
      logic [RATIO_W-1:0]   ratio;
      int                   mode;
   } exp_t;

   exp_t launch_q[$];
   exp_t cmp_q[$];
   int   stub_mode [NUM_REQ] = '{default: 0};
   int   model_ptr = NUM_REQ - 1;
   int   n_pass = 0, n_total = 0;
   int   done_cyc = -100, start_cyc = 0, last_cmp_cyc = 0;
   bit   have_cmp = 0;

   task automatic check(input bit ok, input string name, input longint act, input longint exp);
      n_total++;
      if (ok) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic check_eq(input string name, input longint act, input longint exp);
      check(act == exp, name, act, exp);
   endtask

   task automatic randomize_ops();
      for (int i = 0; i < NUM_REQ; i++) begin
         req_addr[i*ADDR_BITS +: ADDR_BITS] = ADDR_BITS'($urandom);
         req_data[i*DATA_BITS +: DATA_BITS] = DATA_BITS'($urandom);
      end
      cfg_ratio = RATIO_W'($urandom_range(2, 255));
   endtask

   // Predicts the whole grant sequence for a batch: the next pending
   // requester after the last winner, each served once unless held.
   task automatic issue(input logic [NUM_REQ-1:0] mask, input int hold_n);
      logic [NUM_REQ-1:0] pend;
      int p, n;
      exp_t e;
      pend = mask;
      p = model_ptr;
      n = (hold_n > 0) ? hold_n : $countones(mask);
      for (int t = 0; t < n; t++) begin
         for (int k = 1; k <= NUM_REQ; k++) begin
            int id;
            id = (p + k) % NUM_REQ;
            if (pend[id]) begin
               e.id    = id;
               e.addr  = req_addr[id*ADDR_BITS +: ADDR_BITS];
               e.data  = req_data[id*DATA_BITS +: DATA_BITS];
               e.ratio = cfg_ratio;
               e.mode  = stub_mode[id];
               launch_q.push_back(e);
               cmp_q.push_back(e);
               p = id;
               if (hold_n == 0) pend[id] = 1'b0;
               break;
            end
         end
      end
      model_ptr = p;
   endtask

   task automatic run_batch(input logic [NUM_REQ-1:0] mask, input int hold_n,
                            input bit scramble, input bit check_lat);
      logic [NUM_REQ-1:0] pend;
      int got, budget;
      issue(mask, hold_n);
      @(negedge clk);
      req  = mask;
      pend = mask;
      got  = 0;
      if (check_lat) begin
         @(negedge clk);
         check_eq("start_latency", spi_if.spi_start, 1);
      end
      budget = 0;
      while (((hold_n > 0) ? (got < hold_n) : (pend != 0)) && budget < 4000) begin
         @(negedge clk);
         budget++;
         if (scramble && spi_if.spi_start)
            req_data[grant_id*DATA_BITS +: DATA_BITS] = DATA_BITS'($urandom);
         if ((ack | err) != 0) begin
            got++;
            if (hold_n == 0) begin
               pend = pend & ~(ack | err);
               req  = pend;
            end
         end
      end
      if (hold_n > 0) req = '0;
      check(budget < 4000, "batch_timeout", budget, 4000);
      budget = 0;
      while (arb_busy && budget < 100) begin
         @(negedge clk);
         budget++;
      end
      check_eq("arb_idle", arb_busy, 0);
      @(negedge clk);
      check_eq("queues_drained", launch_q.size() + cmp_q.size(), 0);
   endtask

   // Stub SPI master
   initial begin
      int m, k;
      spi_if.spi_busy = 1'b0;
      spi_if.spi_done = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset && spi_if.spi_start) begin
            m = stub_mode[grant_id];
            repeat ($urandom_range(1, 3)) @(negedge clk);
            case (m)
               0: begin
                  spi_if.spi_busy = 1'b1;
                  repeat ($urandom_range(1, 6)) @(negedge clk);
                  spi_if.spi_busy = 1'b0;
                  spi_if.spi_done = 1'b1;
                  done_cyc = cyc;
                  @(negedge clk);
                  spi_if.spi_done = 1'b0;
               end
               1: begin
                  spi_if.spi_done = 1'b1;
                  done_cyc = cyc;
                  @(negedge clk);
                  spi_if.spi_done = 1'b0;
               end
               3: begin
                  spi_if.spi_busy = 1'b1;
                  k = 0;
                  while (!reset && err == '0 && k < 80) begin
                     @(negedge clk);
                     k++;
                  end
                  spi_if.spi_busy = 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   // Monitor / scoreboard
   initial begin
      exp_t e;
      bit prev_busy;
      logic [NUM_REQ-1:0] exp_vec;
      prev_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_busy = 1'b0;
            have_cmp  = 1'b0;
         end else begin
            if (spi_if.spi_start) begin
               check(launch_q.size() != 0, "start_expected", launch_q.size(), 1);
               if (launch_q.size() != 0) begin
                  e = launch_q.pop_front();
                  check_eq("grant_id", grant_id, e.id);
                  check_eq("spi_address", spi_if.spi_address, e.addr);
                  check_eq("spi_data", spi_if.spi_data, e.data);
                  check_eq("spi_ratio", spi_if.spi_ratio, e.ratio);
                  if (have_cmp)
                     check(cyc - last_cmp_cyc >= GAP_CYCLES + 1, "start_gap",
                           cyc - last_cmp_cyc, GAP_CYCLES + 1);
                  start_cyc = cyc;
               end
            end
            if ((ack | err) != 0) begin
               check(cmp_q.size() != 0, "completion_expected", cmp_q.size(), 1);
               if (cmp_q.size() != 0) begin
                  e = cmp_q.pop_front();
                  exp_vec = NUM_REQ'(1) << e.id;
                  check_eq("ack_vec", ack, (e.mode >= 2) ? 0 : exp_vec);
                  check_eq("err_vec", err, (e.mode >= 2) ? exp_vec : 0);
                  if (e.mode < 2)  check_eq("ack_after_done", cyc - done_cyc, 1);
                  if (e.mode == 2) check_eq("wdog_latency", cyc - start_cyc, WDOG_CYCLES + 1);
                  check_eq("held_data", spi_if.spi_data, e.data);
                  last_cmp_cyc = cyc;
                  have_cmp     = 1'b1;
               end
            end
            if (prev_busy && !arb_busy && have_cmp)
               check_eq("gap_len", cyc - last_cmp_cyc, GAP_CYCLES);
            prev_busy = arb_busy;
         end
      end
   end

   initial begin
      int budget;
      repeat (3) @(negedge clk);
      check_eq("rst_grant_id", grant_id, NUM_REQ - 1);
      check_eq("rst_ack_err", {ack, err}, 0);
      check_eq("rst_busy_start", {arb_busy, spi_if.spi_start}, 0);
      reset = 1'b0;

      // Single request with known operands
      randomize_ops();
      req_addr[2*ADDR_BITS +: ADDR_BITS] = 8'h5A;
      req_data[2*DATA_BITS +: DATA_BITS] = 16'hBEEF;
      cfg_ratio = 8'd8;
      run_batch(4'b0100, 0, 0, 1);

      // Park pointer on 3, then hold all requests for five writes
      randomize_ops();
      run_batch(4'b1000, 0, 0, 0);
      randomize_ops();
      run_batch(4'b1111, 5, 0, 0);

      // Pointer at 1: requesters 1 and 3 together -> 3 first
      randomize_ops();
      run_batch(4'b0010, 0, 0, 0);
      randomize_ops();
      run_batch(4'b1010, 0, 1, 0);

      // Watchdog: silent master, then busy stuck
      stub_mode[2] = 2;
      randomize_ops();
      run_batch(4'b0101, 0, 0, 0);
      stub_mode[2] = 0;
      stub_mode[3] = 3;
      randomize_ops();
      run_batch(4'b1000, 0, 1, 0);
      stub_mode[3] = 0;

      for (int b = 0; b < 8; b++) begin
         for (int i = 0; i < NUM_REQ; i++)
            stub_mode[i] = ($urandom_range(0, 9) < 2) ? 2 : int'($urandom_range(0, 1));
         randomize_ops();
         run_batch(NUM_REQ'($urandom_range(1, 15)), 0, 1, 0);
      end
      for (int i = 0; i < NUM_REQ; i++) stub_mode[i] = 0;

      // Asynchronous reset in WAIT_DONE
      stub_mode[1] = 3;
      randomize_ops();
      cfg_ratio = 8'd9;
      issue(4'b0010, 0);
      @(negedge clk);
      req = 4'b0010;
      budget = 0;
      while (!spi_if.spi_busy && budget < 50) begin
         @(negedge clk);
         budget++;
      end
      check_eq("reached_busy", spi_if.spi_busy, 1);
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check_eq("async_grant_id", grant_id, NUM_REQ - 1);
      check_eq("async_ack_err", {ack, err}, 0);
      check_eq("async_busy_start", {arb_busy, spi_if.spi_start}, 0);
      check_eq("async_operands", {spi_if.spi_address, spi_if.spi_data, spi_if.spi_ratio}, 0);
      launch_q.delete();
      cmp_q.delete();
      model_ptr = NUM_REQ - 1;
      req = '0;
      stub_mode[1] = 0;
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      randomize_ops();
      run_batch(4'b0001, 0, 0, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire
